// File: rtl/mdu_hilo.sv
// mdu_hilo: iterative multiply/divide unit with architectural HI/LO registers.
//
// A radix-2 engine does one step per clock for WIDTH clocks. Multiply is
// shift-add and divide is restoring division, both applied to operand
// magnitudes. A final FIX cycle corrects the signs, writes HI/LO and pulses
// DONE. HI/LO keep their old values until that FIX cycle.
//
// Configuration:
//   MDU_DIV_EN  defined   -> divider datapath present (DIVU/DIV)
//               undefined -> OP=1x completes as a no-op one edge after START
//
// Ports:
//   CLK          in   clock, rising edge
//   RST          in   asynchronous reset, active low
//   START        in   begin operation (sampled only in IDLE)
//   OP[1:0]      in   00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   SRC_A        in   rs: multiplicand / dividend / MTHI-MTLO data
//   SRC_B        in   rt: multiplier / divisor
//   HI_WE/LO_WE  in   MTHI/MTLO write strobes (IDLE with START=0 only)
//   BUSY         out  operation in progress
//   DONE         out  one-cycle pulse, HI/LO hold the new result
//   DIV_BY_ZERO  out  valid with DONE, divisor was zero
//   HI/LO        out  architectural HI/LO registers
module mdu_hilo #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             START,
    input  logic [1:0]       OP,
    input  logic [WIDTH-1:0] SRC_A,
    input  logic [WIDTH-1:0] SRC_B,
    input  logic             HI_WE,
    input  logic             LO_WE,
    output logic             BUSY,
    output logic             DONE,
    output logic             DIV_BY_ZERO,
    output logic [WIDTH-1:0] HI,
    output logic [WIDTH-1:0] LO
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_CALC = 2'd1;
    localparam logic [1:0] S_FIX  = 2'd2;
    localparam int CW = $clog2(WIDTH);

    logic [1:0]       state;
    logic [CW-1:0]    cnt;
    logic             neg_p;     // product / quotient negated in FIX
    logic             noop;      // FIX only pulses DONE, HI/LO untouched
    logic             dbz_pend;  // value DIV_BY_ZERO takes at DONE
    logic [WIDTH-1:0] m_r;       // multiplicand or divisor magnitude
    logic [WIDTH-1:0] acc;       // upper product half / partial remainder
    logic [WIDTH-1:0] lo_r;      // multiplier -> low product, dividend -> quotient

    // Operand magnitudes; OP[0] selects the signed variants.
    logic             sa, sb;
    logic [WIDTH-1:0] mag_a, mag_b;
    assign sa    = OP[0] & SRC_A[WIDTH-1];
    assign sb    = OP[0] & SRC_B[WIDTH-1];
    assign mag_a = sa ? -SRC_A : SRC_A;
    assign mag_b = sb ? -SRC_B : SRC_B;

    // Shift-add step: add multiplicand on LSB of multiplier, shift {acc,lo_r} right.
    logic [WIDTH:0] mul_sum;
    assign mul_sum = {1'b0, acc} + (lo_r[0] ? {1'b0, m_r} : '0);

    logic [2*WIDTH-1:0] prod, prod_fix;
    assign prod     = {acc, lo_r};
    assign prod_fix = neg_p ? -prod : prod;

`ifdef MDU_DIV_EN
    logic             is_div;
    logic             neg_r;     // remainder takes the dividend's sign
    // Restoring step. The shifted remainder is WIDTH+1 bits; when the compare
    // succeeds the true difference is below the divisor, so the WIDTH-bit
    // modular subtraction is exact.
    logic [WIDTH:0]   div_sh;
    logic             div_ok;
    logic [WIDTH-1:0] div_rem, quo_fix, rem_fix;
    assign div_sh  = {acc, lo_r[WIDTH-1]};
    assign div_ok  = div_sh >= {1'b0, m_r};
    assign div_rem = div_sh[WIDTH-1:0] - m_r;
    assign quo_fix = neg_p ? -lo_r : lo_r;
    assign rem_fix = neg_r ? -acc : acc;
`endif

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state       <= S_IDLE;
            cnt         <= '0;
            neg_p       <= 1'b0;
            noop        <= 1'b0;
            dbz_pend    <= 1'b0;
            m_r         <= '0;
            acc         <= '0;
            lo_r        <= '0;
            BUSY        <= 1'b0;
            DONE        <= 1'b0;
            DIV_BY_ZERO <= 1'b0;
            HI          <= '0;
            LO          <= '0;
`ifdef MDU_DIV_EN
            is_div      <= 1'b0;
            neg_r       <= 1'b0;
`endif
        end else begin
            DONE <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (START) begin
                        cnt   <= '0;
                        acc   <= '0;
                        neg_p <= sa ^ sb;
`ifdef MDU_DIV_EN
                        is_div <= OP[1];
                        neg_r  <= sa;
                        m_r    <= OP[1] ? mag_b : mag_a;
                        lo_r   <= OP[1] ? mag_a : mag_b;
                        // Zero divisor skips CALC and reports through FIX.
                        if (OP[1] && SRC_B == '0) begin
                            state    <= S_FIX;
                            noop     <= 1'b1;
                            dbz_pend <= 1'b1;
                        end else begin
                            state    <= S_CALC;
                            BUSY     <= 1'b1;
                            noop     <= 1'b0;
                            dbz_pend <= 1'b0;
                        end
`else
                        m_r      <= mag_a;
                        lo_r     <= mag_b;
                        noop     <= OP[1];
                        dbz_pend <= 1'b0;
                        state    <= OP[1] ? S_FIX : S_CALC;
                        BUSY     <= ~OP[1];
`endif
                    end else begin
                        if (HI_WE) HI <= SRC_A;
                        if (LO_WE) LO <= SRC_A;
                    end
                end
                S_CALC: begin
`ifdef MDU_DIV_EN
                    if (is_div) begin
                        acc  <= div_ok ? div_rem : div_sh[WIDTH-1:0];
                        lo_r <= {lo_r[WIDTH-2:0], div_ok};
                    end else
`endif
                    begin
                        acc  <= mul_sum[WIDTH:1];
                        lo_r <= {mul_sum[0], lo_r[WIDTH-1:1]};
                    end
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1)) state <= S_FIX;
                end
                S_FIX: begin
                    state       <= S_IDLE;
                    BUSY        <= 1'b0;
                    DONE        <= 1'b1;
                    DIV_BY_ZERO <= dbz_pend;
                    if (!noop) begin
`ifdef MDU_DIV_EN
                        if (is_div) begin
                            HI <= rem_fix;
                            LO <= quo_fix;
                        end else
`endif
                        begin
                            HI <= prod_fix[2*WIDTH-1:WIDTH];
                            LO <= prod_fix[WIDTH-1:0];
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_hilo.sv
// Directed bench for mdu_hilo: reset values, MTHI/MTLO, multiply and divide
// vectors with hand-computed results, latency/BUSY length, HI/LO stability,
// START/write priority, ignored strobes during CALC and mid-operation reset.
// Divide expectations follow the MDU_DIV_EN build option.
module tb_mdu_hilo;
    logic        CLK = 1'b0;
    logic        RST = 1'b0;
    logic        START = 1'b0;
    logic [1:0]  OP = 2'b00;
    logic [31:0] SRC_A = '0, SRC_B = '0;
    logic        HI_WE = 1'b0, LO_WE = 1'b0;
    logic        BUSY, DONE, DIV_BY_ZERO;
    logic [31:0] HI, LO;

    int n_cmp = 0;
    int n_err = 0;

    mdu_hilo #(.WIDTH(32)) dut (
        .CLK(CLK), .RST(RST), .START(START), .OP(OP),
        .SRC_A(SRC_A), .SRC_B(SRC_B), .HI_WE(HI_WE), .LO_WE(LO_WE),
        .BUSY(BUSY), .DONE(DONE), .DIV_BY_ZERO(DIV_BY_ZERO),
        .HI(HI), .LO(LO)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // MTHI/MTLO in IDLE: strobes seen by exactly one rising edge.
    task automatic mt(input logic hwe, input logic lwe, input logic [31:0] d);
        @(negedge CLK);
        HI_WE = hwe; LO_WE = lwe; SRC_A = d;
        @(negedge CLK);
        HI_WE = 1'b0; LO_WE = 1'b0;
    endtask

    // Issue one operation and follow it to DONE.
    // mode 0: plain; 1: LO_WE raised together with START;
    // 2: HI_WE+START pulsed during CALC.
    // lat counts edges after the START edge up to the DONE edge (100 = timeout).
    task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input int mode, output int lat, output int busy_n, output int unstable);
        logic [31:0] hi0, lo0;
        @(negedge CLK);
        hi0 = HI; lo0 = LO;
        START = 1'b1; OP = op; SRC_A = a; SRC_B = b;
        LO_WE = (mode == 1);
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0; HI_WE = 1'b0; LO_WE = 1'b0;
        lat = 0; busy_n = 0; unstable = 0;
        while (1) begin
            if (BUSY) begin
                busy_n++;
                if (HI !== hi0 || LO !== lo0) unstable++;
            end
            if (DONE || lat >= 100) break;
            if (mode == 2) begin
                if (lat == 5) begin HI_WE = 1'b1; START = 1'b1; SRC_A = 32'hDEAD_BEEF; end
                else if (lat == 6) begin HI_WE = 1'b0; START = 1'b0; end
            end
            @(posedge CLK);
            lat++;
            @(negedge CLK);
        end
    endtask

    int lat, bn, un;
    logic [31:0] hs, ls;

    initial begin
        // reset state
        repeat (2) @(negedge CLK);
        check("rst_busy", {63'd0, BUSY}, 64'd0);
        check("rst_done", {63'd0, DONE}, 64'd0);
        check("rst_dbz", {63'd0, DIV_BY_ZERO}, 64'd0);
        check("rst_hi", {32'd0, HI}, 64'd0);
        check("rst_lo", {32'd0, LO}, 64'd0);
        RST = 1'b1;

        // MTHI
        mt(1'b1, 1'b0, 32'h1234_5678);
        check("mthi_hi", {32'd0, HI}, 64'h1234_5678);
        check("mthi_lo", {32'd0, LO}, 64'd0);

        // MULTU max*max
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, lat, bn, un);
        check("multu_lat", lat, 33);
        check("multu_busy", bn, 33);
        check("multu_stable", un, 0);
        check("multu_res", {HI, LO}, 64'hFFFF_FFFE_0000_0001);
        check("multu_dbz", {63'd0, DIV_BY_ZERO}, 64'd0);
        @(negedge CLK);
        check("done_pulse", {63'd0, DONE}, 64'd0);

        // MULT signed vectors
        run_op(2'b01, 32'hFFFF_FFFD, 32'h0000_0007, 0, lat, bn, un);
        check("mult_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFEB);
        run_op(2'b01, 32'h8000_0000, 32'h8000_0000, 0, lat, bn, un);
        check("mult_min", {HI, LO}, 64'h4000_0000_0000_0000);
        check("mult_lat", lat, 33);

`ifdef MDU_DIV_EN
        run_op(2'b10, 32'd100, 32'd7, 0, lat, bn, un);
        check("divu_res", {HI, LO}, {32'd2, 32'd14});
        check("divu_lat", lat, 33);
        check("divu_busy", bn, 33);
        run_op(2'b11, 32'hFFFF_FFF9, 32'd2, 0, lat, bn, un);
        check("div_neg", {HI, LO}, 64'hFFFF_FFFF_FFFF_FFFD);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, lat, bn, un);
        check("div_wrap", {HI, LO}, 64'h0000_0000_8000_0000);
        mt(1'b1, 1'b0, 32'hAAAA_0000);
        mt(1'b0, 1'b1, 32'h0000_BBBB);
        run_op(2'b11, 32'd5, 32'd0, 0, lat, bn, un);
        check("dbz_lat", lat, 1);
        check("dbz_busy", bn, 0);
        check("dbz_flag", {63'd0, DIV_BY_ZERO}, 64'd1);
        check("dbz_hilo", {HI, LO}, 64'hAAAA_0000_0000_BBBB);
        run_op(2'b00, 32'd2, 32'd2, 0, lat, bn, un);
        check("dbz_clear", {63'd0, DIV_BY_ZERO}, 64'd0);
        check("dbz_next", {HI, LO}, 64'd4);
`else
        hs = HI; ls = LO;
        run_op(2'b10, 32'd100, 32'd7, 0, lat, bn, un);
        check("nodiv_lat", lat, 1);
        check("nodiv_busy", bn, 0);
        check("nodiv_hilo", {HI, LO}, {hs, ls});
        check("nodiv_dbz", {63'd0, DIV_BY_ZERO}, 64'd0);
        run_op(2'b11, 32'd5, 32'd0, 0, lat, bn, un);
        check("nodiv_zero_lat", lat, 1);
        check("nodiv_zero_dbz", {63'd0, DIV_BY_ZERO}, 64'd0);
        check("nodiv_zero_hilo", {HI, LO}, {hs, ls});
`endif

        // START + LO_WE together: the write is dropped
        mt(1'b0, 1'b1, 32'h5555_5555);
        run_op(2'b00, 32'h0000_1000, 32'd3, 1, lat, bn, un);
        check("start_lowe_stable", un, 0);
        check("start_lowe_res", {HI, LO}, 64'h3000);

        // HI_WE and START pulses during CALC are ignored
        run_op(2'b00, 32'h0001_0001, 32'h0001_0001, 2, lat, bn, un);
        check("poke_stable", un, 0);
        check("poke_lat", lat, 33);
        check("poke_res", {HI, LO}, 64'h0000_0001_0002_0001);

        // Reset at CALC iteration 10
        @(negedge CLK);
        START = 1'b1; OP = 2'b00; SRC_A = 32'h0000_0123; SRC_B = 32'h0000_0456;
        @(posedge CLK);
        @(negedge CLK);
        START = 1'b0;
        repeat (10) begin @(posedge CLK); @(negedge CLK); end
        RST = 1'b0;
        #1;
        check("abort_busy", {63'd0, BUSY}, 64'd0);
        check("abort_done", {63'd0, DONE}, 64'd0);
        check("abort_hilo", {HI, LO}, 64'd0);
        check("abort_dbz", {63'd0, DIV_BY_ZERO}, 64'd0);
        @(negedge CLK);
        RST = 1'b1;
        run_op(2'b00, 32'd3, 32'd4, 0, lat, bn, un);
        check("post_rst_res", {HI, LO}, 64'd12);
        check("post_rst_lat", lat, 33);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/mdu_hilo.md
# mdu_hilo

Iterative multiply/divide unit with architectural HI/LO registers for the multicycle MIPS core. It sits directly downstream of the register file and consumes the rs/rt read data (RD1/RD2) during execute, in parallel with the ALU. The control FSM holds in execute while BUSY is high. HI/LO feed the writeback mux for MFHI/MFLO.

## Interface
- WIDTH, 32, operand and HI/LO width

- CLK  in  1  clock, rising-edge active
- RST  in  1  reset, asynchronous, active-low
- START  in  1  begin operation; sampled only in IDLE
- OP  in  2  00 MULTU, 01 MULT, 10 DIVU, 11 DIV
- SRC_A  in  WIDTH  rs value; dividend, multiplicand, or MTHI/MTLO data
- SRC_B  in  WIDTH  rt value; divisor or multiplier
- HI_WE  in  1  MTHI: HI <= SRC_A
- LO_WE  in  1  MTLO: LO <= SRC_A
- BUSY  out  1  operation in progress
- DONE  out  1  one-cycle pulse; HI/LO hold the new result
- DIV_BY_ZERO  out  1  valid with DONE; divisor was zero
- HI  out  WIDTH  HI register
- LO  out  WIDTH  LO register

## Operation
- All outputs are registered.
- Reset values: BUSY=0, DONE=0, DIV_BY_ZERO=0, HI=0, LO=0, state IDLE.
- States:
  - IDLE: START=1 latches OP, |SRC_A|, |SRC_B| and the result signs, clears the counter, and moves to CALC.
  - CALC: one radix-2 step per cycle for 32 cycles. Multiply uses shift-add. Divide uses restoring division. Moves to FIX when the counter reaches 31.
  - FIX: applies sign correction, writes HI/LO, pulses DONE, returns to IDLE.
- Multiply: {HI,LO} = 64-bit product.
  - MULT: operands are two's-complement; the product is negated when the signs differ.
- Divide: LO = quotient, HI = remainder.
  - DIV: quotient sign = signA^signB; remainder sign = sign of the dividend.
  - 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0 (wraps, no trap).
- Division by zero (OP=1x, SRC_B=0 at START):
  - No CALC phase; BUSY stays 0.
  - Next edge: DONE=1, DIV_BY_ZERO=1, HI/LO unchanged.
- DIV_BY_ZERO is cleared on every other DONE.
- HI_WE/LO_WE are honoured only in IDLE with START=0, and write on the next edge. Both may be asserted together.
- START while BUSY is ignored. HI_WE/LO_WE while BUSY are ignored.
- START and HI_WE/LO_WE in the same IDLE cycle: START wins, the write is dropped.
- RST low mid-operation: immediate abort, all outputs take their reset values, no partial HI/LO update.

## Timing
- Edge 0 samples START. BUSY=1 after edge 0.
- Edges 1–32: CALC iterations.
- Edge 33: FIX. HI/LO update, DONE=1, BUSY=0.
- Edge 34: DONE=0. A new START may be sampled on edge 34.
- Fixed latency for multiply and for nonzero divide: 33 edges from the START edge to the result.
- Divide by zero: 1 edge.
- HI/LO are stable whenever BUSY=1; the old values remain readable throughout the operation.

## Configuration
- MDU_DIV_EN defined: divider datapath present; OP=10/11 behave as specified.
- MDU_DIV_EN undefined: no divider logic.
  - OP=10/11 completes as a no-op: DONE pulses one edge after START, BUSY stays 0, HI/LO unchanged, DIV_BY_ZERO stays 0.
  - Multiply behaviour is unaffected.

## Test plan
- MULTU 0xFFFFFFFF × 0xFFFFFFFF -> HI=0xFFFFFFFE, LO=0x00000001; DONE exactly 33 edges after START; BUSY high for 33 cycles.
- MULT 0xFFFFFFFD (−3) × 0x00000007 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB. MULT 0x80000000 × 0x80000000 -> HI=0x40000000, LO=0.
- DIVU 100 / 7 -> LO=14, HI=2. DIV −7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIV 5 / 0 with HI=0xAAAA0000, LO=0x0000BBBB -> DONE and DIV_BY_ZERO after 1 edge; HI/LO unchanged; BUSY never 1. The next MULTU clears DIV_BY_ZERO.
- MTHI 0x12345678 in IDLE -> HI=0x12345678 next edge. START + LO_WE in the same cycle -> LO not written. HI_WE and START pulses during CALC -> ignored, result correct.
- RST low at CALC iteration 10 -> HI=LO=0, BUSY=DONE=0 immediately. After release, MULTU 3 × 4 -> LO=12, HI=0.
